divider_request_arbiter: RTL and testbench

Shares one signed integer divider (ready/valid input and output, in-order results) among REQUESTER_COUNT independent requesters. Requests are granted round-robin. A tag FIFO records the requester index of each in-flight operation so every result returns to its originator. The block sits between client pipelines and a single divider instance; the divider itself is external and connected through the div_* ports.

---
 rtl/divider_request_arbiter.sv | 133 +++++++++++++
 tb/tb_divider_request_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_request_arbiter.sv
// Round-robin front end that shares one in-order divider among REQUESTER_COUNT clients.
// Grant and result steering are zero-latency; a full tag FIFO or a stalled head requester blocks all traffic.
module divider_request_arbiter #(
  parameter int WORD_WIDTH      = 8,
  parameter int REQUESTER_COUNT = 3,
  parameter int MAX_IN_FLIGHT   = 4
) (
  input  logic                                  clock,
  input  logic                                  clear,
  input  logic [REQUESTER_COUNT-1:0]            req_valid,
  output logic [REQUESTER_COUNT-1:0]            req_ready,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_dividend,
  input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_divisor,
  output logic [REQUESTER_COUNT-1:0]            rsp_valid,
  input  logic [REQUESTER_COUNT-1:0]            rsp_ready,
  output logic [WORD_WIDTH-1:0]                 rsp_quotient,
  output logic [WORD_WIDTH-1:0]                 rsp_remainder,
  output logic                                  rsp_divide_by_zero,
  output logic                                  div_input_valid,
  input  logic                                  div_input_ready,
  output logic [WORD_WIDTH-1:0]                 div_dividend,
  output logic [WORD_WIDTH-1:0]                 div_divisor,
  input  logic                                  div_output_valid,
  output logic                                  div_output_ready,
  input  logic [WORD_WIDTH-1:0]                 div_quotient,
  input  logic [WORD_WIDTH-1:0]                 div_remainder,
  input  logic                                  div_divide_by_zero,
  output logic                                  tag_underflow
);

  localparam int TAG_WIDTH = $clog2(REQUESTER_COUNT);
  localparam int IDX_WIDTH = TAG_WIDTH + 1;
  localparam int CNT_WIDTH = $clog2(MAX_IN_FLIGHT + 1);
  localparam int PTR_WIDTH = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;

  logic [TAG_WIDTH-1:0] prio_ptr;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic                 grant_found;
  logic [IDX_WIDTH-1:0] cand;

  logic [TAG_WIDTH-1:0] tag_mem [MAX_IN_FLIGHT];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] occupancy;
  logic [TAG_WIDTH-1:0] head_tag;

  logic full;
  logic empty;
  logic issue;
  logic pop;

  assign full  = (occupancy == CNT_WIDTH'(MAX_IN_FLIGHT));
  assign empty = (occupancy == '0);

  // Scan requesters starting at the priority pointer, wrapping past the last index.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < REQUESTER_COUNT; k++) begin
      cand = {1'b0, prio_ptr} + IDX_WIDTH'(k);
      if (cand >= IDX_WIDTH'(REQUESTER_COUNT)) begin
        cand = cand - IDX_WIDTH'(REQUESTER_COUNT);
      end
      if (!grant_found && req_valid[cand[TAG_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[TAG_WIDTH-1:0];
      end
    end
  end

  assign div_input_valid = (|req_valid) & ~full;
  assign issue           = div_input_valid & div_input_ready;
  assign div_dividend    = grant_found ? req_dividend[grant_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
  assign div_divisor     = grant_found ? req_divisor[grant_idx*WORD_WIDTH +: WORD_WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (grant_found && div_input_ready && !full) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Results come back in issue order, so the FIFO head always names the owner.
  assign head_tag         = tag_mem[rd_ptr];
  assign div_output_ready = ~empty & rsp_ready[head_tag];
  assign pop              = div_output_valid & div_output_ready;

  always_comb begin
    rsp_valid = '0;
    if (div_output_valid && !empty) begin
      rsp_valid[head_tag] = 1'b1;
    end
  end

  assign rsp_quotient       = div_quotient;
  assign rsp_remainder      = div_remainder;
  assign rsp_divide_by_zero = div_divide_by_zero;

  always_ff @(posedge clock) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      prio_ptr      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      tag_underflow <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr   <= (wr_ptr == PTR_WIDTH'(MAX_IN_FLIGHT - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
        prio_ptr <= (grant_idx == TAG_WIDTH'(REQUESTER_COUNT - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_WIDTH'(MAX_IN_FLIGHT - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
      end
      // Full blocks issue, so push and pop never over- or underrun the counter.
      case ({issue, pop})
        2'b10:   occupancy <= occupancy + CNT_WIDTH'(1);
        2'b01:   occupancy <= occupancy - CNT_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
      if (div_output_valid && empty) begin
        tag_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_divider_request_arbiter.sv
// Bench for divider_request_arbiter: vector table, directed corner sequences and random traffic.
// A queue-based model of the arbiter and an external divider model supply every expected value.
module tb_divider_request_arbiter;

  localparam int N = 3;
  localparam int W = 8;
  localparam int D = 4;

  logic             clock = 1'b0;
  logic             clear;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_dividend, req_divisor;
  logic [W-1:0]     rsp_quotient, rsp_remainder, div_dividend, div_divisor;
  logic [W-1:0]     div_quotient, div_remainder;
  logic             rsp_divide_by_zero, div_input_valid, div_input_ready;
  logic             div_output_valid, div_output_ready, div_divide_by_zero, tag_underflow;

  always #5 clock = ~clock;

  divider_request_arbiter #(.WORD_WIDTH(W), .REQUESTER_COUNT(N), .MAX_IN_FLIGHT(D)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_divide_by_zero(rsp_divide_by_zero),
    .div_input_valid(div_input_valid), .div_input_ready(div_input_ready),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_output_valid(div_output_valid), .div_output_ready(div_output_ready),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_divide_by_zero(div_divide_by_zero),
    .tag_underflow(tag_underflow)
  );

  typedef struct { logic [W-1:0] q; logic [W-1:0] r; logic z; } res_t;
  typedef struct { int tag; res_t res; } op_t;
  typedef struct {
    logic [N-1:0] rv; logic dir; logic dov; logic [N-1:0] rr;
    logic [N-1:0] e_rdy; logic e_vld; logic [N-1:0] e_rsp; logic e_ordy;
  } vec_t;

  op_t  inflight[$];
  res_t div_q[$];
  int   rr_ptr;
  logic uf;
  int   grant_log[$];
  int   rsp_log[$];
  int   total = 0;
  int   bad = 0;

  bit         use_div_model;
  bit         div_gate;
  logic       man_dov, man_z;
  logic [W-1:0] man_q, man_r;

  vec_t tbl[13];

  function automatic res_t divide(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) begin
      res.q = '1; res.r = a; res.z = 1'b1;
    end else begin
      res.q = W'(sa / sb); res.r = W'(sa % sb); res.z = 1'b0;
    end
    return res;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] rv, input logic dir, input logic dov,
                              input logic [N-1:0] rr, input logic [N-1:0] e_rdy,
                              input logic e_vld, input logic [N-1:0] e_rsp, input logic e_ordy);
    vec_t v;
    v.rv = rv; v.dir = dir; v.dov = dov; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_rsp = e_rsp; v.e_ordy = e_ordy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_div();
    if (use_div_model) begin
      if (div_gate && div_q.size() > 0) begin
        div_output_valid = 1'b1;
        div_quotient = div_q[0].q; div_remainder = div_q[0].r; div_divide_by_zero = div_q[0].z;
      end else begin
        div_output_valid = 1'b0;
        div_quotient = '0; div_remainder = '0; div_divide_by_zero = 1'b0;
      end
    end else begin
      div_output_valid = man_dov;
      div_quotient = man_q; div_remainder = man_r; div_divide_by_zero = man_z;
    end
  endtask

  // One clock: drive divider side, check all outputs against the model, then advance the model.
  task automatic cycle();
    int g, h;
    bit full, empty, issue, pop;
    logic [N-1:0] e_rdy, e_rsp;
    res_t res;
    drive_div();
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(rr_ptr + k) % N]) g = (rr_ptr + k) % N;
    end
    full  = (inflight.size() == D);
    empty = (inflight.size() == 0);
    h     = empty ? 0 : inflight[0].tag;
    issue = (g >= 0) && !full && div_input_ready;
    pop   = !empty && div_output_valid && rsp_ready[h];
    e_rdy = '0;
    if (issue) e_rdy[g] = 1'b1;
    e_rsp = '0;
    if (!empty && div_output_valid) e_rsp[h] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("div_input_valid", 32'(div_input_valid), 32'((g >= 0) && !full));
    chk("div_dividend", 32'(div_dividend), (g >= 0) ? 32'(req_dividend[g*W +: W]) : 32'd0);
    chk("div_divisor", 32'(div_divisor), (g >= 0) ? 32'(req_divisor[g*W +: W]) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("div_output_ready", 32'(div_output_ready), 32'(!empty && rsp_ready[h]));
    chk("rsp_quotient_pass", 32'(rsp_quotient), 32'(div_quotient));
    chk("tag_underflow", 32'(tag_underflow), 32'(uf));
    if (pop && use_div_model) begin
      chk("e2e_quotient", 32'(rsp_quotient), 32'(inflight[0].res.q));
      chk("e2e_remainder", 32'(rsp_remainder), 32'(inflight[0].res.r));
      chk("e2e_dbz", 32'(rsp_divide_by_zero), 32'(inflight[0].res.z));
    end
    if (!clear) begin
      for (int i = 0; i < N; i++) begin
        if (div_input_valid && div_input_ready && req_ready[i]) grant_log.push_back(i);
        if (div_output_valid && div_output_ready && rsp_valid[i]) rsp_log.push_back(i);
      end
    end
    @(posedge clock);
    if (clear) begin
      inflight.delete(); div_q.delete(); rr_ptr = 0; uf = 1'b0;
    end else begin
      if (pop) begin
        void'(inflight.pop_front());
        if (use_div_model) void'(div_q.pop_front());
      end
      if (empty && div_output_valid) uf = 1'b1;
      if (issue) begin
        op_t op;
        res = divide(req_dividend[g*W +: W], req_divisor[g*W +: W]);
        op.tag = g; op.res = res;
        inflight.push_back(op);
        div_q.push_back(res);
        rr_ptr = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_clear();
    req_valid = '0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    req_valid = '0; rsp_ready = '0; div_input_ready = 1'b0;
    req_dividend = '0; req_divisor = '0;
    use_div_model = 1'b0; div_gate = 1'b1;
    man_dov = 1'b0; man_q = '0; man_r = '0; man_z = 1'b0;
    drive_div();
    rr_ptr = 0; uf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;

    // rv, dir, dov, rr -> req_ready, div_input_valid, rsp_valid, div_output_ready
    tbl[0]  = mk(3'b000, 1, 0, 3'b111, 3'b000, 0, 3'b000, 0);
    tbl[1]  = mk(3'b110, 0, 0, 3'b111, 3'b000, 1, 3'b000, 0);
    tbl[2]  = mk(3'b110, 1, 0, 3'b111, 3'b010, 1, 3'b000, 0);
    tbl[3]  = mk(3'b011, 1, 1, 3'b010, 3'b001, 1, 3'b010, 1);
    tbl[4]  = mk(3'b000, 1, 1, 3'b000, 3'b000, 0, 3'b001, 0);
    tbl[5]  = mk(3'b111, 1, 1, 3'b001, 3'b010, 1, 3'b001, 1);
    tbl[6]  = mk(3'b111, 1, 0, 3'b111, 3'b100, 1, 3'b000, 1);
    tbl[7]  = mk(3'b111, 1, 0, 3'b111, 3'b001, 1, 3'b000, 1);
    tbl[8]  = mk(3'b111, 1, 0, 3'b111, 3'b010, 1, 3'b000, 1);
    tbl[9]  = mk(3'b111, 1, 1, 3'b111, 3'b000, 0, 3'b010, 1);
    tbl[10] = mk(3'b100, 1, 1, 3'b011, 3'b100, 1, 3'b100, 0);
    tbl[11] = mk(3'b000, 1, 0, 3'b000, 3'b000, 0, 3'b000, 0);
    tbl[12] = mk(3'b111, 1, 0, 3'b100, 3'b000, 0, 3'b000, 1);

    req_dividend = {8'h33, 8'h22, 8'h11};
    req_divisor  = {8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].rv; div_input_ready = tbl[i].dir; rsp_ready = tbl[i].rr;
      man_dov = tbl[i].dov; man_q = W'(8'hA0 + i); man_r = W'(8'h50 + i); man_z = i[0];
      drive_div();
      #1;
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_div_in_vld", i), 32'(div_input_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rsp));
      chk($sformatf("tbl%0d_div_out_rdy", i), 32'(div_output_ready), 32'(tbl[i].e_ordy));
      chk($sformatf("tbl%0d_rsp_rem", i), 32'(rsp_remainder), 32'(8'h50 + i));
      cycle();
    end
    man_dov = 1'b0;
    do_clear();

    // Signed division pass-through and divide-by-zero flag.
    use_div_model = 1'b1; div_gate = 1'b1; rsp_ready = '1; div_input_ready = 1'b1;
    req_dividend = {8'h00, 8'h05, 8'hF9};
    req_divisor  = {8'h01, 8'h00, 8'h02};
    req_valid = 3'b001; cycle(); req_valid = '0;
    drive_div(); #1;
    chk("neg7_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("neg7_quotient", 32'(rsp_quotient), 32'hFD);
    chk("neg7_remainder", 32'(rsp_remainder), 32'hFF);
    chk("neg7_dbz", 32'(rsp_divide_by_zero), 32'h0);
    cycle();
    req_valid = 3'b010; cycle(); req_valid = '0;
    drive_div(); #1;
    chk("dbz_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("dbz_flag", 32'(rsp_divide_by_zero), 32'h1);
    chk("dbz_quotient", 32'(rsp_quotient), 32'hFF);
    chk("dbz_remainder", 32'(rsp_remainder), 32'h05);
    cycle();

    // Round robin with everybody requesting and the divider always ready.
    do_clear();
    grant_log.delete(); rsp_log.delete();
    req_valid = 3'b111;
    repeat (8) cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("rr_grant_count", 32'(grant_log.size()), 32'd8);
    chk("rr_rsp_count", 32'(rsp_log.size()), 32'd8);
    for (int i = 0; i < 6 && i < grant_log.size() && i < rsp_log.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 3));
      chk($sformatf("rr_rsp%0d", i), 32'(rsp_log[i]), 32'(i % 3));
    end

    // Fill the tag FIFO with results held back, then drain in issue order.
    do_clear();
    grant_log.delete(); rsp_log.delete();
    rsp_ready = '0; req_valid = 3'b111;
    repeat (8) cycle();
    chk("full_issue_count", 32'(grant_log.size()), 32'(D));
    drive_div(); #1;
    chk("full_div_in_vld", 32'(div_input_valid), 32'h0);
    chk("full_req_ready", 32'(req_ready), 32'h0);
    rsp_ready = '1;
    repeat (6) cycle();
    chk("full_resumed", 32'(grant_log.size() > D), 32'h1);
    for (int i = 0; i < D && i < rsp_log.size(); i++) begin
      chk($sformatf("drain_order%0d", i), 32'(rsp_log[i]), 32'(i % 3));
    end
    req_valid = '0;
    repeat (6) cycle();

    // Clear with three operations in flight; pointer must return to 0.
    do_clear();
    grant_log.delete(); rsp_log.delete();
    rsp_ready = '0; req_valid = 3'b010;
    repeat (3) cycle();
    chk("pre_clear_issues", 32'(grant_log.size()), 32'd3);
    do_clear();
    rsp_ready = '1; rsp_log.delete();
    req_dividend = {8'h64, 8'h05, 8'hF9};
    req_divisor  = {8'hF9, 8'h00, 8'h02};
    req_valid = 3'b101;
    drive_div(); #1;
    chk("post_clear_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_clear_ptr0", 32'(req_ready), 32'h1);
    cycle();
    req_valid = 3'b100; cycle(); req_valid = '0;
    drive_div(); #1;
    chk("req2_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("req2_quotient", 32'(rsp_quotient), 32'hF2);
    chk("req2_remainder", 32'(rsp_remainder), 32'h02);
    cycle();
    chk("post_clear_rsp_count", 32'(rsp_log.size()), 32'd2);

    // Divider result with nothing in flight.
    do_clear();
    use_div_model = 1'b0; man_dov = 1'b1; man_q = 8'h12; man_r = 8'h34; man_z = 1'b0;
    drive_div(); #1;
    chk("uf_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("uf_out_ready", 32'(div_output_ready), 32'h0);
    chk("uf_before", 32'(tag_underflow), 32'h0);
    cycle();
    man_dov = 1'b0;
    repeat (3) cycle();
    chk("uf_sticky", 32'(tag_underflow), 32'h1);
    do_clear();
    drive_div(); #1;
    chk("uf_cleared", 32'(tag_underflow), 32'h0);

    // Random traffic against the model.
    use_div_model = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      req_valid       = N'($urandom);
      req_dividend    = (N*W)'({$urandom, $urandom});
      req_divisor     = (N*W)'({$urandom, $urandom}) & {N{8'h8F}};
      rsp_ready       = N'($urandom) | N'($urandom);
      div_input_ready = ($urandom_range(0, 3) != 0);
      div_gate        = ($urandom_range(0, 2) != 0);
      clear           = ($urandom_range(0, 199) == 0);
      cycle();
    end
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
